// File: rtl/spi_share_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_share_arbiter : round-robin, non-preemptive sharing of one SPI master
//                     between two requesters, with drain, idle gap and hold timeout.
// Revision: 1.0
// ----------------------------------------------------------------------------
module spi_share_arbiter #(
  parameter int GapCycles = 2
) (
  input  logic        Clk_i,
  input  logic        Reset_n_i,
  input  logic        Req0_i,
  output logic        Grant0_o,
  input  logic        Write0_i,
  input  logic        ReadNext0_i,
  input  logic [7:0]  Data0_i,
  input  logic        CPOL0_i,
  input  logic        CPHA0_i,
  input  logic        LSBFE0_i,
  input  logic        Req1_i,
  output logic        Grant1_o,
  input  logic        Write1_i,
  input  logic        ReadNext1_i,
  input  logic [7:0]  Data1_i,
  input  logic        CPOL1_i,
  input  logic        CPHA1_i,
  input  logic        LSBFE1_i,
  output logic        SPI_Write_o,
  output logic        SPI_ReadNext_o,
  output logic [7:0]  SPI_Data_o,
  output logic        SPI_CPOL_o,
  output logic        SPI_CPHA_o,
  output logic        SPI_LSBFE_o,
  input  logic        SPI_Transmission_i,
  input  logic        SPI_FIFOEmpty_i,
  input  logic [15:0] HoldTimeoutPreset_i,
  output logic        HoldTimeout_o,
  output logic        LastGrant_o
);

  localparam logic [3:0] GapLoad = 4'(GapCycles - 1);

  typedef enum logic [2:0] {
    stIdle  = 3'd0,
    stOwn0  = 3'd1,
    stOwn1  = 3'd2,
    stDrain = 3'd3,
    stGap   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        grant0_q, grant0_d;
  logic        grant1_q, grant1_d;
  logic        last_grant_q, last_grant_d;
  logic        hold_to_q, hold_to_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  logic [15:0] to_cnt_q, to_cnt_d;

  always_comb begin
    state_d      = state_q;
    grant0_d     = grant0_q;
    grant1_d     = grant1_q;
    last_grant_d = last_grant_q;
    hold_to_d    = 1'b0;
    gap_cnt_d    = gap_cnt_q;
    to_cnt_d     = to_cnt_q;
    case (state_q)
      stIdle: begin
        // On a tie the requester that did not own the bus last time wins.
        if (Req0_i && (!Req1_i || last_grant_q)) begin
          state_d      = stOwn0;
          grant0_d     = 1'b1;
          last_grant_d = 1'b0;
          to_cnt_d     = HoldTimeoutPreset_i;
        end else if (Req1_i) begin
          state_d      = stOwn1;
          grant1_d     = 1'b1;
          last_grant_d = 1'b1;
          to_cnt_d     = HoldTimeoutPreset_i;
        end
      end
      stOwn0: begin
        if (!Req0_i) begin
          state_d  = stDrain;
          grant0_d = 1'b0;
        end else if (Req1_i && (to_cnt_q != 16'd0)) begin
          to_cnt_d  = to_cnt_q - 16'd1;
          hold_to_d = (to_cnt_q == 16'd1);
        end
      end
      stOwn1: begin
        if (!Req1_i) begin
          state_d  = stDrain;
          grant1_d = 1'b0;
        end else if (Req0_i && (to_cnt_q != 16'd0)) begin
          to_cnt_d  = to_cnt_q - 16'd1;
          hold_to_d = (to_cnt_q == 16'd1);
        end
      end
      stDrain: begin
        if (!SPI_Transmission_i && SPI_FIFOEmpty_i) begin
          state_d   = stGap;
          gap_cnt_d = GapLoad;
        end
      end
      stGap: begin
        if (gap_cnt_q == 4'd0) begin
          state_d = stIdle;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d  = stIdle;
        grant0_d = 1'b0;
        grant1_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      state_q      <= stIdle;
      grant0_q     <= 1'b0;
      grant1_q     <= 1'b0;
      last_grant_q <= 1'b1;
      hold_to_q    <= 1'b0;
      gap_cnt_q    <= 4'd0;
      to_cnt_q     <= 16'd0;
    end else begin
      state_q      <= state_d;
      grant0_q     <= grant0_d;
      grant1_q     <= grant1_d;
      last_grant_q <= last_grant_d;
      hold_to_q    <= hold_to_d;
      gap_cnt_q    <= gap_cnt_d;
      to_cnt_q     <= to_cnt_d;
    end
  end

  always_comb begin
    SPI_Write_o    = 1'b0;
    SPI_ReadNext_o = 1'b0;
    SPI_Data_o     = 8'h00;
    SPI_CPOL_o     = 1'b0;
    SPI_CPHA_o     = 1'b0;
    SPI_LSBFE_o    = 1'b0;
    case (state_q)
      stOwn0: begin
        SPI_Write_o    = Write0_i;
        SPI_ReadNext_o = ReadNext0_i;
        SPI_Data_o     = Data0_i;
        SPI_CPOL_o     = CPOL0_i;
        SPI_CPHA_o     = CPHA0_i;
        SPI_LSBFE_o    = LSBFE0_i;
      end
      stOwn1: begin
        SPI_Write_o    = Write1_i;
        SPI_ReadNext_o = ReadNext1_i;
        SPI_Data_o     = Data1_i;
        SPI_CPOL_o     = CPOL1_i;
        SPI_CPHA_o     = CPHA1_i;
        SPI_LSBFE_o    = LSBFE1_i;
      end
      default: ;
    endcase
  end

  assign Grant0_o      = grant0_q;
  assign Grant1_o      = grant1_q;
  assign HoldTimeout_o = hold_to_q;
  assign LastGrant_o   = last_grant_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_share_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_spi_share_arbiter : scoreboard bench for spi_share_arbiter (GapCycles = 2).
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_spi_share_arbiter;

  localparam int KG0 = 0;
  localparam int KG1 = 1;
  localparam int KTO = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, write0, rnext0, cpol0, cpha0, lsbfe0;
  logic        req1, write1, rnext1, cpol1, cpha1, lsbfe1;
  logic [7:0]  data0, data1;
  logic        trans, fifo_empty;
  logic [15:0] preset;
  logic        grant0, grant1, spi_write, spi_rnext, spi_cpol, spi_cpha, spi_lsbfe;
  logic [7:0]  spi_data;
  logic        hold_to, last_grant;

  typedef struct {
    int kind;
    int cyc;
  } evt_t;

  evt_t exp_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   to_hi_cnt = 0;
  logic p_g0 = 1'b0, p_g1 = 1'b0, p_to = 1'b0;

  spi_share_arbiter #(.GapCycles(2)) dut (
    .Clk_i(clk), .Reset_n_i(rst_n),
    .Req0_i(req0), .Grant0_o(grant0), .Write0_i(write0), .ReadNext0_i(rnext0),
    .Data0_i(data0), .CPOL0_i(cpol0), .CPHA0_i(cpha0), .LSBFE0_i(lsbfe0),
    .Req1_i(req1), .Grant1_o(grant1), .Write1_i(write1), .ReadNext1_i(rnext1),
    .Data1_i(data1), .CPOL1_i(cpol1), .CPHA1_i(cpha1), .LSBFE1_i(lsbfe1),
    .SPI_Write_o(spi_write), .SPI_ReadNext_o(spi_rnext), .SPI_Data_o(spi_data),
    .SPI_CPOL_o(spi_cpol), .SPI_CPHA_o(spi_cpha), .SPI_LSBFE_o(spi_lsbfe),
    .SPI_Transmission_i(trans), .SPI_FIFOEmpty_i(fifo_empty),
    .HoldTimeoutPreset_i(preset), .HoldTimeout_o(hold_to), .LastGrant_o(last_grant)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_evt(input int kind, input int at);
    evt_t e;
    e.kind = kind;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic got_evt(input int kind);
    evt_t e;
    if (exp_q.size() == 0) begin
      check_eq($sformatf("unexpected_event_kind%0d", kind), 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq("event_kind", kind, e.kind);
      check_eq("event_cycle", cyc, e.cyc);
    end
  endtask

  // Rising grants and timeout pulses are the DUT's observable output events.
  always @(negedge clk) begin
    if (rst_n) begin
      if (grant0 && !p_g0) got_evt(KG0);
      if (grant1 && !p_g1) got_evt(KG1);
      if (hold_to && !p_to) got_evt(KTO);
      if (hold_to) to_hi_cnt <= to_hi_cnt + 1;
    end
    p_g0 <= grant0;
    p_g1 <= grant1;
    p_to <= hold_to;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check_eq("pending_events", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {req0, write0, rnext0, cpol0, cpha0, lsbfe0, data0} = '0;
    {req1, write1, rnext1, cpol1, cpha1, lsbfe1, data1} = '0;
    trans = 1'b0;
    fifo_empty = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check_eq("rst_grant0", grant0, 1'b0);
    check_eq("rst_grant1", grant1, 1'b0);
    check_eq("rst_hold_to", hold_to, 1'b0);
    check_eq("rst_last_grant", last_grant, 1'b1);
    check_eq("rst_spi_data", spi_data, 8'h00);
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, d, e, f, g, r, base;
    preset = 16'd0;
    do_reset();

    // Single requester: grant latency and SPI mux from owner 0 only.
    step();
    c = cyc;
    req0 = 1'b1; write0 = 1'b1; data0 = 8'hA5; cpol0 = 1'b1; lsbfe0 = 1'b1;
    write1 = 1'b0; rnext1 = 1'b1; data1 = 8'h5A; cpha1 = 1'b1;
    push_evt(KG0, c + 1);
    @(negedge clk);
    check_eq("pre_grant_spi_write", spi_write, 1'b0);
    step();
    @(negedge clk);
    check_eq("own0_grant1", grant1, 1'b0);
    check_eq("own0_spi_write", spi_write, 1'b1);
    check_eq("own0_spi_data", spi_data, 8'hA5);
    check_eq("own0_mode", {spi_cpol, spi_cpha, spi_lsbfe}, 3'b101);
    check_eq("own0_rnext", spi_rnext, 1'b0);
    check_eq("own0_last_grant", last_grant, 1'b0);
    write0 = 1'b0; rnext0 = 1'b1;
    #1;
    check_eq("own0_spi_write_follow", spi_write, 1'b0);
    check_eq("own0_rnext_follow", spi_rnext, 1'b1);
    step();
    req0 = 1'b0; rnext0 = 1'b0;
    step();
    @(negedge clk);
    check_eq("rel0_grant0", grant0, 1'b0);
    check_eq("rel0_spi_data", spi_data, 8'h00);
    repeat (6) step();
    wait_drain(10);

    // Tie after reset, then gap spacing, then tie favouring requester 0 again.
    do_reset();
    step();
    c = cyc;
    req0 = 1'b1; req1 = 1'b1;
    push_evt(KG0, c + 1);
    repeat (3) step();
    d = cyc;
    req0 = 1'b0;
    push_evt(KG1, d + 5);
    repeat (4) step();
    @(negedge clk);
    check_eq("gap_no_early_grant1", grant1, 1'b0);
    step();
    @(negedge clk);
    check_eq("gap_grant1", grant1, 1'b1);
    check_eq("gap_last_grant", last_grant, 1'b1);
    repeat (2) step();
    e = cyc;
    req1 = 1'b0;
    push_evt(KG0, e + 5);
    step();
    req0 = 1'b1; req1 = 1'b1;
    repeat (4) step();
    @(negedge clk);
    check_eq("tie2_grant0", grant0, 1'b1);
    check_eq("tie2_grant1", grant1, 1'b0);

    // Hand over to owner 1, then owner 1 releases while the master is still busy.
    f = cyc;
    req0 = 1'b0;
    push_evt(KG1, f + 5);
    repeat (5) step();
    @(negedge clk);
    check_eq("handover_grant1", grant1, 1'b1);
    repeat (2) step();
    g = cyc;
    req1 = 1'b0; req0 = 1'b1; write1 = 1'b1;
    trans = 1'b1; fifo_empty = 1'b0;
    push_evt(KG0, g + 16);
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 10) trans = 1'b0;
      if (k == 12) fifo_empty = 1'b1;
      @(negedge clk);
      check_eq($sformatf("drain_spi_write_k%0d", k), spi_write, 1'b0);
      check_eq($sformatf("drain_grant0_k%0d", k), grant0, (k >= 16));
    end
    write1 = 1'b0;
    wait_drain(10);

    // Hold timeout: Req1 waits while owner 0 keeps the bus.
    do_reset();
    preset = 16'd20;
    base = to_hi_cnt;
    step();
    c = cyc;
    req0 = 1'b1;
    push_evt(KG0, c + 1);
    repeat (6) step();
    r = cyc;
    req1 = 1'b1;
    push_evt(KTO, r + 20);
    repeat (19) step();
    @(negedge clk);
    check_eq("to_not_early", hold_to, 1'b0);
    step();
    @(negedge clk);
    check_eq("to_pulse", hold_to, 1'b1);
    step();
    @(negedge clk);
    check_eq("to_one_cycle", hold_to, 1'b0);
    repeat (30) step();
    @(negedge clk);
    check_eq("to_grant0_kept", grant0, 1'b1);
    check_eq("to_grant1_low", grant1, 1'b0);
    check_eq("to_pulse_count", to_hi_cnt - base, 1);

    // Asynchronous reset in the middle of an owner-1 session.
    d = cyc;
    req0 = 1'b0;
    push_evt(KG1, d + 5);
    repeat (5) step();
    write1 = 1'b1; data1 = 8'h3C;
    @(negedge clk);
    check_eq("own1_spi_data", spi_data, 8'h3C);
    check_eq("own1_spi_write", spi_write, 1'b1);
    req0 = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_grant1", grant1, 1'b0);
    check_eq("async_spi_write", spi_write, 1'b0);
    check_eq("async_spi_data", spi_data, 8'h00);
    check_eq("async_hold_to", hold_to, 1'b0);
    repeat (2) step();
    r = cyc;
    rst_n = 1'b1;
    push_evt(KG0, r + 1);
    step();
    @(negedge clk);
    check_eq("post_rst_grant0", grant0, 1'b1);
    check_eq("post_rst_grant1", grant1, 1'b0);
    wait_drain(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
